// File: rtl/mem_read_arbiter.sv
// Two-requester (icache/dcache) refill arbiter in front of one memory read port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; the default build is icache-first.
module mem_read_arbiter #(
  parameter int                    DATA_WIDTH       = 64,
  parameter int                    ADDR_WIDTH       = 64,
  parameter int                    CACHE_LINE_WIDTH = 256,
  parameter logic [ADDR_WIDTH-1:0] DATA_OFFSET      = 64'h0000_0000_0000_D000
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_icache_read_req,
  input  logic [ADDR_WIDTH-1:0]       i_icache_read_address,
  output logic [CACHE_LINE_WIDTH-1:0] o_icache_cache_line,
  output logic                        o_icache_read_done,
  input  logic                        i_dcache_read_req,
  input  logic [ADDR_WIDTH-1:0]       i_dcache_read_address,
  output logic [CACHE_LINE_WIDTH-1:0] o_dcache_cache_line,
  output logic                        o_dcache_read_done,
  output logic                        o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
  input  logic                        i_mem_read_done,
  input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line
);

  if (CACHE_LINE_WIDTH % DATA_WIDTH != 0) begin : g_bad_cfg
    $error("CACHE_LINE_WIDTH must be a multiple of DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_owner_d;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [CACHE_LINE_WIDTH-1:0] r_iline;
  logic [CACHE_LINE_WIDTH-1:0] r_dline;
  logic                        w_grant;
  logic                        w_grant_d;
  logic                        w_busy;
  logic                        w_resp;

  assign w_grant = i_icache_read_req | i_dcache_read_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // On a tie the side not served last time wins.
  assign w_grant_d = i_dcache_read_req &
                     (~i_icache_read_req | ~r_last_d);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_d <= 1'b1;
    end else if (r_state == IDLE && w_grant) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = i_dcache_read_req & ~i_icache_read_req;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_next = w_grant_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (i_mem_read_done) begin
          w_next = RESP;
        end
      end
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_owner_d <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_grant) begin
        r_owner_d <= w_grant_d;
        r_addr    <= w_grant_d ?
                     i_dcache_read_address + DATA_OFFSET :
                     i_icache_read_address;
      end
    end
  end

  // Only the owner's line register is written; the other one holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_iline <= '0;
      r_dline <= '0;
    end else if (i_mem_read_done) begin
      if (r_state == BUSY_I) begin
        r_iline <= i_cache_line;
      end
      if (r_state == BUSY_D) begin
        r_dline <= i_cache_line;
      end
    end
  end

  assign w_busy = (r_state == BUSY_I) | (r_state == BUSY_D);
  assign w_resp = (r_state == RESP);

  assign o_mem_read_req      = w_busy;
  assign o_mem_read_address  = w_busy ? r_addr : '0;
  assign o_icache_read_done  = w_resp & ~r_owner_d;
  assign o_dcache_read_done  = w_resp & r_owner_d;
  assign o_icache_cache_line = r_iline;
  assign o_dcache_cache_line = r_dline;

endmodule
